// File: rtl/bus_controller.sv
// ---------------------------------------------------------------------------
// bus_controller
//
// Sequences the multiplexed 16-bit external memory bus for two internal
// requesters: instruction fetch and data load/store. Data has fixed priority
// over fetch. Every access runs IDLE -> ADDR -> DATA -> RECOVER. DATA can be
// stretched by programmable wait states and by the external nWait pin. An
// access that waits too long is ended with a bus error.
//
// Parameters
//   WAIT_STATES : forced wait cycles at the start of DATA (0..255)
//   MAX_WAIT    : nWait-low cycles allowed after the forced waits before the
//                 access times out (1..255)
//
// Ports
//   Clock, nReset          : clock (rising edge), async active-low reset
//   FetchReq/FetchAddr     : fetch request level and address
//   FetchAck               : one-cycle fetch completion pulse
//   DataReq/DataWr/DataAddr/DataWData : data request, direction, address,
//                            write data
//   DataAck                : one-cycle data completion pulse
//   RData                  : read data, held until the next read capture
//   BusErr                 : pulses with the Ack of a timed-out access
//   BusOut/BusIn           : external bus value out / sampled in
//   ALE, nME, nOE, nWE, ENB: external bus strobes and pad drive enable
//   nWait                  : external wait request, active low
//   Busy                   : high whenever the controller is not IDLE
// ---------------------------------------------------------------------------
module bus_controller #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned MAX_WAIT    = 15
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        FetchReq,
    input  logic [15:0] FetchAddr,
    output logic        FetchAck,
    input  logic        DataReq,
    input  logic        DataWr,
    input  logic [15:0] DataAddr,
    input  logic [15:0] DataWData,
    output logic        DataAck,
    output logic [15:0] RData,
    output logic        BusErr,
    output logic [15:0] BusOut,
    input  logic [15:0] BusIn,
    output logic        ALE,
    output logic        nME,
    output logic        nOE,
    output logic        nWE,
    output logic        ENB,
    input  logic        nWait,
    output logic        Busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_DATA    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);
    localparam logic [7:0] WAIT_MAX  = 8'(MAX_WAIT);

    state_t      r_state;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_wr;       // latched direction, 1 = write
    logic        r_is_data;  // latched requester, 1 = data, 0 = fetch
    logic [7:0]  r_wait_cnt; // forced wait cycles still to run
    logic [7:0]  r_to_cnt;   // nWait-low cycles seen after the forced waits

    logic        w_grant_data;
    logic        w_wait_done;
    logic        w_timeout;
    logic        w_finish;

    // NOTE: everything below that reads state is pure combinational decode;
    // every signal gets a value on every path so no latch can be inferred.
    always_comb begin
        w_grant_data = DataReq;
        w_wait_done  = (r_wait_cnt == 8'd0);
        w_timeout    = 1'b0;
        w_finish     = 1'b0;
        if (r_state == S_DATA && w_wait_done) begin
            // The timeout fires on the nWait-low cycle that brings the
            // counter up to MAX_WAIT, so exactly MAX_WAIT such cycles run.
            w_timeout = !nWait && ((r_to_cnt + 8'd1) == WAIT_MAX);
            w_finish  = nWait || w_timeout;
        end
    end

    assign Busy = (r_state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the values from before the edge regardless of order.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state    <= S_IDLE;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_wr       <= 1'b0;
            r_is_data  <= 1'b0;
            r_wait_cnt <= 8'd0;
            r_to_cnt   <= 8'd0;
            ALE        <= 1'b0;
            nME        <= 1'b1;
            nOE        <= 1'b1;
            nWE        <= 1'b1;
            ENB        <= 1'b0;
            BusOut     <= 16'h0000;
            RData      <= 16'h0000;
            FetchAck   <= 1'b0;
            DataAck    <= 1'b0;
            BusErr     <= 1'b0;
        end else begin
            // Completion pulses last a single cycle.
            FetchAck <= 1'b0;
            DataAck  <= 1'b0;
            BusErr   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (DataReq || FetchReq) begin
                        r_is_data <= w_grant_data;
                        r_wr      <= w_grant_data && DataWr;
                        r_addr    <= w_grant_data ? DataAddr : FetchAddr;
                        r_wdata   <= DataWData;
                        r_state   <= S_ADDR;
                        // Strobes are registered, so drive the ADDR values now.
                        ALE       <= 1'b1;
                        nME       <= 1'b0;
                        ENB       <= 1'b1;
                        BusOut    <= w_grant_data ? DataAddr : FetchAddr;
                    end
                end

                S_ADDR: begin
                    r_wait_cnt <= WAIT_INIT;
                    r_to_cnt   <= 8'd0;
                    r_state    <= S_DATA;
                    ALE        <= 1'b0;
                    if (r_wr) begin
                        ENB    <= 1'b1;
                        BusOut <= r_wdata;
                        nWE    <= 1'b0;
                    end else begin
                        // Pads are released on the same edge that nOE falls;
                        // both are registered so they never overlap.
                        ENB    <= 1'b0;
                        BusOut <= 16'h0000;
                        nOE    <= 1'b0;
                    end
                end

                S_DATA: begin
                    if (!w_wait_done) begin
                        r_wait_cnt <= r_wait_cnt - 8'd1;
                    end else if (w_finish) begin
                        r_state  <= S_RECOVER;
                        nME      <= 1'b1;
                        nOE      <= 1'b1;
                        nWE      <= 1'b1;
                        ENB      <= 1'b0;
                        BusOut   <= 16'h0000;
                        FetchAck <= !r_is_data;
                        DataAck  <= r_is_data;
                        BusErr   <= w_timeout;
                        if (!r_wr) begin
                            RData <= w_timeout ? 16'hFFFF : BusIn;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end

                S_RECOVER: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The core must never drive the pads while the memory drives them.
    ast_enb_noe: assert property (@(posedge Clock) disable iff (!nReset)
        !(ENB && !nOE));

endmodule

// File: tb/tb_bus_controller.sv
// ---------------------------------------------------------------------------
// tb_bus_controller
//
// Drives directed and randomized accesses into bus_controller and compares
// every cycle of every access against a transaction-level model: each access
// is described by its requester, direction, address, data and the number of
// nWait-low cycles, and the model derives the expected phase sequence, Ack,
// BusErr and RData from the controller's timing rules.
// ---------------------------------------------------------------------------
module tb_bus_controller;

    localparam int WS = 2;
    localparam int MW = 15;

    logic        Clock;
    logic        nReset;
    logic        FetchReq;
    logic [15:0] FetchAddr;
    logic        FetchAck;
    logic        DataReq;
    logic        DataWr;
    logic [15:0] DataAddr;
    logic [15:0] DataWData;
    logic        DataAck;
    logic [15:0] RData;
    logic        BusErr;
    logic [15:0] BusOut;
    logic [15:0] BusIn;
    logic        ALE;
    logic        nME;
    logic        nOE;
    logic        nWE;
    logic        ENB;
    logic        nWait;
    logic        Busy;

    bus_controller #(
        .WAIT_STATES(WS),
        .MAX_WAIT   (MW)
    ) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .FetchReq (FetchReq),
        .FetchAddr(FetchAddr),
        .FetchAck (FetchAck),
        .DataReq  (DataReq),
        .DataWr   (DataWr),
        .DataAddr (DataAddr),
        .DataWData(DataWData),
        .DataAck  (DataAck),
        .RData    (RData),
        .BusErr   (BusErr),
        .BusOut   (BusOut),
        .BusIn    (BusIn),
        .ALE      (ALE),
        .nME      (nME),
        .nOE      (nOE),
        .nWE      (nWE),
        .ENB      (ENB),
        .nWait    (nWait),
        .Busy     (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Strobe vector: {ALE,nME,nOE,nWE,ENB,Busy,FetchAck,DataAck,BusErr}
    localparam logic [8:0] V_IDLE  = 9'b0_1_1_1_0_0_0_0_0;
    localparam logic [8:0] V_ADDR  = 9'b1_0_1_1_1_1_0_0_0;
    localparam logic [8:0] V_WRITE = 9'b0_0_1_0_1_1_0_0_0;
    localparam logic [8:0] V_READ  = 9'b0_0_0_1_0_1_0_0_0;

    int n_checks = 0;
    int n_pass   = 0;

    // Requester model state.
    bit          fetch_pend = 1'b0;
    bit          data_pend  = 1'b0;
    logic [15:0] f_addr     = 16'h0;
    logic [15:0] d_addr     = 16'h0;
    logic [15:0] d_wdata    = 16'h0;
    bit          d_wr       = 1'b0;
    logic [15:0] exp_rdata  = 16'h0;
    bit          use_fixed  = 1'b0;
    logic [15:0] fixed_bus  = 16'h0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [8:0] strobes();
        return {ALE, nME, nOE, nWE, ENB, Busy, FetchAck, DataAck, BusErr};
    endfunction

    // Runs one access. Entered at the negedge of an IDLE cycle; returns at
    // the negedge of the IDLE cycle that follows RECOVER. `low` is the number
    // of nWait-low cycles after the forced waits; `tmo` holds nWait low.
    task automatic run_access(input int low, input bit tmo);
        bit          is_data;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] cap;
        int          dlen;
        int          j;
        is_data = data_pend;
        wr      = data_pend && d_wr;
        addr    = data_pend ? d_addr : f_addr;
        wd      = d_wdata;
        cap     = 16'h0;
        dlen    = tmo ? (WS + MW) : (WS + low + 1);

        check("idle_strobes", 32'(strobes()), 32'(V_IDLE));
        check("idle_busout", 32'(BusOut), 32'h0);

        FetchReq  = fetch_pend;
        DataReq   = data_pend;
        DataWr    = d_wr;
        FetchAddr = f_addr;
        DataAddr  = d_addr;
        DataWData = d_wdata;
        nWait     = 1'($urandom);
        BusIn     = 16'($urandom);

        for (int k = 1; k <= dlen + 1; k++) begin
            @(negedge Clock);
            if (k == 1) begin
                check("addr_strobes", 32'(strobes()), 32'(V_ADDR));
                check("addr_busout", 32'(BusOut), 32'(addr));
            end else if (wr) begin
                check("wdata_strobes", 32'(strobes()), 32'(V_WRITE));
                check("wdata_busout", 32'(BusOut), 32'(wd));
            end else begin
                check("rdata_strobes", 32'(strobes()), 32'(V_READ));
                check("rdata_busout", 32'(BusOut), 32'h0);
            end
            // Addresses are latched at grant; disturbing them must not matter.
            FetchAddr = 16'($urandom);
            DataAddr  = 16'($urandom);
            DataWData = 16'($urandom);
            // Inputs for the edge that ends cycle k.
            j = k - 2;
            if (k == 1 || j < WS) nWait = 1'($urandom);
            else if (tmo)         nWait = 1'b0;
            else                  nWait = (j - WS < low) ? 1'b0 : 1'b1;
            BusIn = 16'($urandom);
            if (k == dlen + 1) begin
                if (use_fixed) BusIn = fixed_bus;
                cap = BusIn;
            end
        end

        @(negedge Clock);
        check("recover_strobes", 32'(strobes()),
              32'({6'b0_1_1_1_0_1, !is_data, is_data, tmo}));
        check("recover_busout", 32'(BusOut), 32'h0);
        if (!wr) exp_rdata = tmo ? 16'hFFFF : cap;
        check("rdata", 32'(RData), 32'(exp_rdata));

        if (is_data) data_pend = 1'b0;
        else         fetch_pend = 1'b0;
        FetchReq  = fetch_pend;
        DataReq   = data_pend;
        FetchAddr = f_addr;
        DataAddr  = d_addr;
        DataWData = d_wdata;
        nWait     = 1'b1;
        use_fixed = 1'b0;
        @(negedge Clock);
    endtask

    initial begin
        nReset    = 1'b0;
        FetchReq  = 1'b0;
        FetchAddr = 16'h0;
        DataReq   = 1'b0;
        DataWr    = 1'b0;
        DataAddr  = 16'h0;
        DataWData = 16'h0;
        BusIn     = 16'h0;
        nWait     = 1'b1;

        #12;
        check("reset_strobes", 32'(strobes()), 32'(V_IDLE));
        check("reset_busout", 32'(BusOut), 32'h0);
        check("reset_rdata", 32'(RData), 32'h0);
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);

        // Fetch read, no external waits.
        fetch_pend = 1'b1; f_addr = 16'h0040;
        use_fixed = 1'b1; fixed_bus = 16'h1234;
        run_access(0, 1'b0);
        check("fetch_rdata_1234", 32'(exp_rdata), 32'h1234);

        // Data write.
        data_pend = 1'b1; d_wr = 1'b1; d_addr = 16'h8002; d_wdata = 16'hBEEF;
        run_access(0, 1'b0);

        // Simultaneous requests: data first, then fetch.
        data_pend = 1'b1; d_wr = 1'b0; d_addr = 16'h1111;
        fetch_pend = 1'b1; f_addr = 16'h2222;
        run_access(1, 1'b0);
        run_access(0, 1'b0);

        // Read with three external wait cycles after the forced waits.
        data_pend = 1'b1; d_wr = 1'b0; d_addr = 16'h3000;
        run_access(3, 1'b0);

        // Permanent nWait low: timeout, then a normal access.
        fetch_pend = 1'b1; f_addr = 16'h0100;
        run_access(0, 1'b1);
        check("timeout_rdata", 32'(RData), 32'hFFFF);
        data_pend = 1'b1; d_wr = 1'b0; d_addr = 16'h0104;
        run_access(2, 1'b0);

        // Write after a timeout: RData must still hold 16'hFFFF-free value.
        data_pend = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h5A5A;
        run_access(0, 1'b1);

        // Async reset during DATA of a write with a fetch pending.
        data_pend = 1'b1; d_wr = 1'b1; d_addr = 16'h4444; d_wdata = 16'hCAFE;
        fetch_pend = 1'b1; f_addr = 16'h0888;
        FetchReq = 1'b1; DataReq = 1'b1; DataWr = 1'b1;
        FetchAddr = f_addr; DataAddr = d_addr; DataWData = d_wdata;
        @(negedge Clock);
        @(negedge Clock);
        check("pre_reset_write", 32'(strobes()), 32'(V_WRITE));
        #3 nReset = 1'b0;
        #1;
        check("reset_mid_strobes", 32'(strobes()), 32'(V_IDLE));
        check("reset_mid_busout", 32'(BusOut), 32'h0);
        check("reset_mid_rdata", 32'(RData), 32'h0);
        exp_rdata = 16'h0;
        data_pend = 1'b0;
        DataReq   = 1'b0;
        @(negedge Clock);
        nReset = 1'b1;
        run_access(0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            if (!fetch_pend && !data_pend && $urandom_range(0, 4) == 0) begin
                check("gap_strobes", 32'(strobes()), 32'(V_IDLE));
                FetchReq = 1'b0;
                DataReq  = 1'b0;
                @(negedge Clock);
            end
            if (!data_pend && $urandom_range(0, 1) == 1) begin
                data_pend = 1'b1;
                d_wr      = 1'($urandom);
                d_addr    = 16'($urandom);
                d_wdata   = 16'($urandom);
            end
            if (!fetch_pend && (!data_pend || $urandom_range(0, 1) == 1)) begin
                fetch_pend = 1'b1;
                f_addr     = 16'($urandom);
            end
            run_access($urandom_range(0, 4), $urandom_range(0, 7) == 0);
        end
        while (fetch_pend || data_pend) run_access(0, 1'b0);
        check("final_idle", 32'(strobes()), 32'(V_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
- Sequences the CPU's multiplexed 16-bit external memory bus (ALE, nME, nOE, nWE, ENB, nWait) on behalf of two internal requesters: instruction fetch and data load/store.
- Sits between the control/datapath pair and the core's external pins.
- Arbitrates between requesters, inserts programmable and externally requested wait states, and terminates hung accesses with a bus error.

Parameters:
- WAIT_STATES, 0: minimum number of forced wait cycles in the DATA phase.
- MAX_WAIT, 15: maximum cycles in DATA beyond WAIT_STATES while nWait is low before timeout; range 1..255.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- nReset  in  1  asynchronous active-low reset.
- FetchReq  in  1  instruction fetch request; level, held until FetchAck.
- FetchAddr  in  16  fetch address.
- FetchAck  out  1  one-cycle completion pulse for fetch.
- DataReq  in  1  data access request; level, held until DataAck.
- DataWr  in  1  1 = write, 0 = read; qualified by DataReq.
- DataAddr  in  16  data address.
- DataWData  in  16  write data.
- DataAck  out  1  one-cycle completion pulse for data access.
- RData  out  16  read data; valid while the corresponding Ack is high and held until the next read capture.
- BusErr  out  1  pulses together with the Ack of a timed-out access.
- BusOut  out  16  value driven on the external bus.
- BusIn  in  16  value sampled from the external bus.
- ALE  out  1  address latch enable, active high.
- nME  out  1  memory enable, active low.
- nOE  out  1  output enable (read strobe), active low.
- nWE  out  1  write enable, active low.
- ENB  out  1  bus drive enable; 1 = core drives BusOut onto the pads.
- nWait  in  1  external wait request, active low; sampled synchronously.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; ALE=0, nME=1, nOE=1, nWE=1, ENB=0, BusOut=0, RData=0, FetchAck=0, DataAck=0, BusErr=0, Busy=0. Reset mid-access aborts the access with no Ack.
- All outputs are registered, or decoded only from registered state and counters.
- IDLE: all strobes inactive, BusOut=0.
  - If DataReq=1: grant data. DataReq has fixed priority over FetchReq.
  - Else if FetchReq=1: grant fetch.
  - On grant, latch address, write data, direction and requester, then go to ADDR.
- ADDR (1 cycle): ALE=1, nME=0, ENB=1, BusOut=latched address. Load wait counter with WAIT_STATES, clear timeout counter, go to DATA.
- DATA:
  - ALE=0, nME=0.
  - Write: ENB=1, BusOut=wdata, nWE=0, nOE=1.
  - Read: ENB=0, BusOut=0, nOE=0, nWE=1.
  - While the wait counter is nonzero, decrement it each cycle; nWait is ignored.
  - Once the wait counter is 0:
    - If nWait=1: completion. On a read, capture BusIn into RData at this edge. Go to RECOVER.
    - If nWait=0: increment the timeout counter. When it reaches MAX_WAIT, go to RECOVER with the error flag set; on a read, RData=16'hFFFF.
- RECOVER (1 cycle): ALE=0, nME=1, nOE=1, nWE=1, ENB=0, BusOut=0. The granted requester's Ack=1. BusErr=1 if the error flag is set. Go to IDLE.
- Latency with WAIT_STATES=0 and nWait=1: request sampled in IDLE at edge N; ADDR is cycle N+1, DATA is N+2, Ack is high in cycle N+3. Each wait cycle adds 1.
- Back-to-back accesses: minimum 4 cycles per access, because IDLE always occupies at least one cycle.
- Requester protocol:
  - Deassert Req, or present the next request, on the edge where Ack is sampled high.
  - Req and address must remain stable from grant until Ack. The controller uses latched copies, so later changes are harmless.
- Simultaneous DataReq and FetchReq: data is served first; fetch is granted in the IDLE cycle following DataAck if still requested.
- Starvation: not prevented. Control never issues more than one data access per instruction.
- FetchAck and DataAck are never high in the same cycle.
- ENB and nOE are never simultaneously asserted (ENB=1 with nOE=0 is illegal). This is a required assertion.
- nME is deasserted for at least one cycle between consecutive accesses.

Test Plan:
- Fetch read, WAIT_STATES=0, nWait=1, FetchAddr=16'h0040, BusIn=16'h1234 -> ALE=1 with BusOut=16'h0040 at N+1; nOE=0 at N+2; FetchAck and RData=16'h1234 at N+3; BusErr=0.
- Data write, DataAddr=16'h8002, DataWData=16'hBEEF -> ADDR drives 16'h8002 with ENB=1; DATA drives 16'hBEEF with nWE=0 and ENB=1; DataAck at N+3; nOE stays 1 throughout.
- DataReq and FetchReq raised in the same cycle -> data access completes first; fetch ALE appears one cycle after DataAck; Acks never overlap.
- WAIT_STATES=2 with nWait held low for 3 extra cycles on a read -> DATA lasts 6 cycles; Ack at N+8; RData equals BusIn sampled on the final DATA edge.
- nWait held low permanently, MAX_WAIT=15, read -> Ack and BusErr both pulse after 15 timeout cycles; RData=16'hFFFF; controller returns to IDLE and serves the next request normally.
- nReset asserted asynchronously during DATA of a write -> nWE, nME and ENB go inactive immediately; no Ack; after release, a pending FetchReq starts in ADDR 2 cycles later.
